// File: rtl/display_scan_controller.sv
// Multiplexed 7-segment scan controller: one shared nibble decoder, one-hot digit enables,
// dead-time blanking between digits and a double-buffered display value.
module display_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  lzb,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int CMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = $clog2(DIGITS);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   active_q, active_d;
  logic [4*DIGITS-1:0]   pbuf_q, pbuf_d;
  logic                  pend_q, pend_d;
  logic                  fdone_d;
  logic                  copy;

  logic [3:0]            nibble_q, nibble_d;
  logic [DIGITS-1:0]     sel_q, sel_d;
  logic                  fdone_q;

  logic [DIGITS-1:0]     sup;
  logic                  upper_zero;
  logic [IW-1:0]         disp_idx;
  logic [3:0]            nib_sel;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    pbuf_d   = pbuf_q;
    pend_d   = pend_q;
    fdone_d  = 1'b0;
    copy     = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SHOW;
          idx_d   = '0;
          cnt_d   = '0;
          copy    = 1'b1;
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              fdone_d = 1'b1;
              copy    = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // A load coinciding with the boundary copy moves the old pending value and keeps the new one.
    if (copy && pend_q) begin
      active_d = pbuf_q;
      pend_d   = 1'b0;
    end
    if (load) begin
      pbuf_d = value;
      pend_d = 1'b1;
    end
  end

  // Leading-zero suppression mask, derived from the buffer that will be on display.
  always_comb begin
    upper_zero = 1'b1;
    sup        = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (active_d[4*i +: 4] == 4'd0);
      sup[i]     = lzb & upper_zero;
    end
  end

  // During BLANK the decoder is already fed the upcoming digit.
  always_comb begin
    disp_idx = idx_d;
    if (state_d == BLANK) begin
      disp_idx = (idx_d == IDX_LAST) ? '0 : idx_d + IW'(1);
    end
    nib_sel = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (disp_idx == IW'(i)) begin
        nib_sel = active_d[4*i +: 4];
      end
    end
  end

  always_comb begin
    nibble_d = (state_d == IDLE) ? 4'd0 : nib_sel;
    sel_d    = '0;
    if (state_d == SHOW && !sup[idx_d]) begin
      sel_d = DIGITS'(1) << idx_d;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      active_q <= '0;
      pbuf_q   <= '0;
      pend_q   <= 1'b0;
      nibble_q <= 4'd0;
      sel_q    <= '0;
      fdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      pbuf_q   <= pbuf_d;
      pend_q   <= pend_d;
      nibble_q <= nibble_d;
      sel_q    <= sel_d;
      fdone_q  <= fdone_d;
    end
  end

  assign nibble     = nibble_q;
  assign digit_sel  = sel_q;
  assign frame_done = fdone_q;
  assign pending    = pend_q;

endmodule
